// File: rtl/decoder_rr_sched.sv
// Round-robin scheduler for the shared 3-to-8 select decoder.
// Break-before-make: code settles before en rises and holds after it falls.
module decoder_rr_sched #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       en,
  output logic       busy,
  output logic       start
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    GRANT,
    GAP
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam bit               HOLD_ON   = (HOLD_CYCLES != 0);

  state_t           state;
  state_t           state_n;
  logic [2:0]       code;
  logic [2:0]       ptr;
  logic [2:0]       winner;
  logic             found;
  logic             rel;
  logic [CNT_W-1:0] cnt;

  assign a = code[2];
  assign b = code[1];
  assign c = code[0];

  // First requester after the last grantee, wrapping 7 -> 0
  always_comb begin
    logic [2:0] idx;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Grant ends on done, dropped request, or dwell limit
  always_comb begin
    rel = done | ~req[code];
    if (HOLD_ON && cnt == HOLD_LAST)
      rel = 1'b1;
  end

  // Next-state selection
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (found) state_n = SETUP;
      SETUP: state_n = GRANT;
      GRANT: if (rel) state_n = GAP;
      GAP:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Registered code, pointer, dwell counter and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code  <= '0;
      ptr   <= 3'd7;
      cnt   <= '0;
      en    <= 1'b0;
      busy  <= 1'b0;
      start <= 1'b0;
    end else begin
      en    <= (state_n == GRANT);
      busy  <= (state_n != IDLE);
      start <= (state == SETUP);
      if (state == IDLE && found)
        code <= winner;
      if (state == SETUP)
        cnt <= '0;
      else if (state == GRANT)
        cnt <= cnt + 1'b1;
      if (state == GAP)
        ptr <= code;
    end
  end

endmodule

// File: tb/tb_decoder_rr_sched.sv
// Bench for decoder_rr_sched: vector table, corner sequences,
// and random traffic against a grant-timeline reference model.
module tb_decoder_rr_sched;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       a, b, c, en, busy, start;

  int checks   = 0;
  int failures = 0;

  decoder_rr_sched #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .done (done),
    .a    (a),
    .b    (b),
    .c    (c),
    .en   (en),
    .busy (busy),
    .start(start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic       en;
    logic [2:0] code;
    logic       busy;
    logic       start;
  } vec_t;

  vec_t tbl [9];

  // Reference model: grant timeline in terms of owner and age
  int         m_chan;
  int         m_age;
  int         m_last;
  bit         m_gap;
  logic [2:0] m_code;
  logic       m_en;
  logic       m_start;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req  = 8'h00;
    done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic model_reset();
    m_chan  = -1;
    m_age   = 0;
    m_last  = 7;
    m_gap   = 0;
    m_code  = 3'd0;
    m_en    = 1'b0;
    m_start = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    m_start = 1'b0;
    if (m_chan < 0) begin
      if (r != 8'h00) begin
        for (int k = 1; k <= 8; k++) begin
          int j;
          j = (m_last + k) % 8;
          if (r[j]) begin
            m_chan = j;
            break;
          end
        end
        m_code = m_chan[2:0];
        m_age  = 0;
        m_gap  = 0;
        m_en   = 1'b0;
      end
    end else if (m_gap) begin
      m_last = m_chan;
      m_chan = -1;
      m_gap  = 0;
    end else if (m_age == 0) begin
      m_age   = 1;
      m_en    = 1'b1;
      m_start = 1'b1;
    end else if (d || !r[m_chan] || (H != 0 && m_age == H)) begin
      m_en  = 1'b0;
      m_gap = 1;
    end else begin
      m_age++;
    end
  endtask

  task automatic wait_start(output int got, output bit ok);
    got = -1;
    ok  = 0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (start) begin
        got = int'({a, b, c});
        ok  = 1;
        break;
      end
    end
  endtask

  initial begin
    int  g;
    bit  ok;
    int  n;
    int  ens;
    logic [5:0] exp_v;

    tbl[0] = '{8'h20, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0};
    tbl[1] = '{8'h20, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1};
    tbl[2] = '{8'h20, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0};
    tbl[3] = '{8'h20, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0};
    tbl[4] = '{8'h20, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0};
    tbl[5] = '{8'h20, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0};
    tbl[6] = '{8'h20, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0};
    tbl[7] = '{8'h20, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0};
    tbl[8] = '{8'h20, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1};

    // Reset mid-cycle with no requests
    #3 rst = 1'b1;
    #1;
    chk("rst_en", int'(en), 0);
    chk("rst_code", int'({a, b, c}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_start", int'(start), 0);
    @(negedge clk);
    rst = 1'b0;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({en, busy, start, a, b, c} != 6'd0) ok = 0;
    end
    chk("idle_quiet", int'(ok), 1);

    // Single requester on channel 5, vector table
    do_reset();
    foreach (tbl[i]) begin
      req  = tbl[i].req;
      done = tbl[i].done;
      tick();
      chk("tbl_en", int'(en), int'(tbl[i].en));
      chk("tbl_code", int'({a, b, c}), int'(tbl[i].code));
      chk("tbl_busy", int'(busy), int'(tbl[i].busy));
      chk("tbl_start", int'(start), int'(tbl[i].start));
    end

    // All requesting: strict rotation from channel 0
    do_reset();
    req = 8'hFF;
    n = 0;
    for (int cyc = 0; cyc < 200 && n < 9; cyc++) begin
      tick();
      if (start) begin
        chk("rr_order", int'({a, b, c}), n % 8);
        n++;
      end
    end
    chk("rr_count", n, 9);

    // Pointer wrap: after 6, request {6,0} gives 0 then 6
    do_reset();
    req = 8'h40;
    wait_start(g, ok);
    chk("wrap_first", g, 6);
    req = 8'h41;
    wait_start(g, ok);
    chk("wrap_second", g, 0);
    wait_start(g, ok);
    chk("wrap_third", g, 6);

    // Early release by done in the second GRANT cycle
    do_reset();
    req = 8'h08;
    wait_start(g, ok);
    chk("done_code", g, 3);
    chk("done_en1", int'(en), 1);
    tick();
    chk("done_en2", int'(en), 1);
    done = 1'b1;
    tick();
    chk("done_en_off", int'(en), 0);
    chk("done_code_hold", int'({a, b, c}), 3);
    done = 1'b0;
    req  = 8'h00;
    ens = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      ens += int'(en);
    end
    chk("done_no_more", ens, 0);

    // Request dropped during SETUP still gets one GRANT cycle
    do_reset();
    req = 8'h08;
    tick();
    chk("drop_setup_busy", int'(busy), 1);
    chk("drop_setup_en", int'(en), 0);
    req = 8'h00;
    ens = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      ens += int'(en);
    end
    chk("drop_en_cycles", ens, 1);

    // Asynchronous reset while granted
    do_reset();
    req = 8'h80;
    wait_start(g, ok);
    chk("mid_code", g, 7);
    #2 rst = 1'b1;
    #1;
    chk("mid_en", int'(en), 0);
    chk("mid_busy", int'(busy), 0);
    chk("mid_code0", int'({a, b, c}), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("mid_setup_en", int'(en), 0);
    chk("mid_setup_busy", int'(busy), 1);
    tick();
    chk("mid_regrant_en", int'(en), 1);
    chk("mid_regrant_start", int'(start), 1);
    chk("mid_regrant_code", int'({a, b, c}), 7);

    // Random traffic against the reference model
    do_reset();
    model_reset();
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) req = 8'($urandom);
      done = ($urandom_range(7) == 0);
      tick();
      model_edge(req, done);
      exp_v = {m_en, (m_chan >= 0), m_start, m_code};
      if ({en, busy, start, a, b, c} != exp_v) n++;
      if (n < 10)
        chk("rand_outputs", int'({en, busy, start, a, b, c}), int'(exp_v));
    end
    chk("rand_mismatch_total", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
